// File: rtl/rst_seq_sync.sv
// Reset synchroniser and staggered multi-domain reset sequencer with a four-phase soft-reset handshake.
// Optional reset-event counter and rst_evt_cnt port are built only when RST_EVT_CNT_EN is defined.
module rst_seq_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_DOMAINS = 4,
   parameter int STAGGER     = 8,
   parameter int SOFT_PULSE  = 16,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   ready,
   input  logic                   soft_req,
   output logic                   soft_ack
`ifdef RST_EVT_CNT_EN
   ,
   output logic [CNT_W-1:0]       rst_evt_cnt
`endif
);

   localparam int MAX_LOAD = (STAGGER > SOFT_PULSE) ? STAGGER : SOFT_PULSE;
   localparam int CW       = $clog2(MAX_LOAD + 1);

   typedef enum logic [2:0] {
      HOLD,
      SYNC,
      REL,
      SOFT,
      ACK,
      RUN
   } state_t;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_seq_sync: SYNC_STAGES must be >= 2");
   end
   if (NUM_DOMAINS < 1) begin : g_bad_dom
      $error("rst_seq_sync: NUM_DOMAINS must be >= 1");
   end
   if (STAGGER < 1 || SOFT_PULSE < 1) begin : g_bad_time
      $error("rst_seq_sync: STAGGER and SOFT_PULSE must be >= 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("rst_seq_sync: CNT_W must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic                   soft_seq;
   logic [NUM_DOMAINS-1:0] rel_next;
   logic                   last_rel;
   logic                   cnt_done;
   logic                   ack_set;

   // Release of reset_n is shifted through a chain of ones; assertion clears it with no clock.
   // NOTE: async reset in the sensitivity list makes assertion immediate even with clk stopped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = sync[SYNC_STAGES-1];

   // Domains release in order, so the released set is always a thermometer code.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rel_next = '0;
      rel_next = (rst_n_out << 1) | NUM_DOMAINS'(1);
   end

   assign last_rel = &rel_next;
   assign cnt_done = (cnt == CW'(1));
   assign ack_set  = (state == REL) && cnt_done && (&rst_n_out) && soft_seq;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HOLD;
         cnt       <= '0;
         soft_seq  <= 1'b0;
         rst_n_out <= '0;
         ready     <= 1'b0;
         soft_ack  <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               state <= SYNC;
            end

            SYNC: begin
               if (sync_out) begin
                  rst_n_out <= rel_next;
                  cnt       <= last_rel ? CW'(1) : CW'(STAGGER);
                  state     <= REL;
               end
            end

            // One extra count after the last domain gives the settle cycle before ready.
            REL: begin
               if (cnt_done) begin
                  if (&rst_n_out) begin
                     ready <= 1'b1;
                     if (soft_seq) begin
                        soft_ack <= 1'b1;
                        state    <= ACK;
                     end else begin
                        state <= RUN;
                     end
                  end else begin
                     rst_n_out <= rel_next;
                     cnt       <= last_rel ? CW'(1) : CW'(STAGGER);
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            SOFT: begin
               if (cnt_done) begin
                  rst_n_out <= rel_next;
                  cnt       <= last_rel ? CW'(1) : CW'(STAGGER);
                  state     <= REL;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            RUN: begin
               if (soft_req) begin
                  rst_n_out <= '0;
                  ready     <= 1'b0;
                  cnt       <= CW'(SOFT_PULSE);
                  soft_seq  <= 1'b1;
                  state     <= SOFT;
               end
            end

            ACK: begin
               if (!soft_req) begin
                  soft_ack <= 1'b0;
                  soft_seq <= 1'b0;
                  state    <= RUN;
               end
            end

            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

`ifdef RST_EVT_CNT_EN
   // Counts completed soft resets; sticks at all-ones until the next reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_evt_cnt <= '0;
      end else if (ack_set && !(&rst_evt_cnt)) begin
         rst_evt_cnt <= rst_evt_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rst_seq_sync.sv
// Directed bench for rst_seq_sync: power-on timing, async abort, soft-reset handshakes,
// early request, reset in ACK with a sub-cycle glitch, and the optional event counter.
module tb_rst_seq_sync;

   logic       clk;
   logic       clk_en;
   logic       reset_n;
   logic [3:0] rst_n_out;
   logic       ready;
   logic       soft_req;
   logic       soft_ack;
`ifdef RST_EVT_CNT_EN
   logic [1:0] rst_evt_cnt;
`endif

   int n_vec;
   int n_err;
   int cur;
   int e;

   rst_seq_sync #(
      .SYNC_STAGES(2),
      .NUM_DOMAINS(4),
      .STAGGER    (8),
      .SOFT_PULSE (16),
      .CNT_W      (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rst_n_out  (rst_n_out),
      .ready      (ready),
      .soft_req   (soft_req),
      .soft_ack   (soft_ack)
`ifdef RST_EVT_CNT_EN
      ,
      .rst_evt_cnt(rst_evt_cnt)
`endif
   );

   // Clock stays stopped until the first reset release; first posedge is 5 units later.
   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever begin
         #5 clk = 1'b1;
         #5 clk = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to edge k counted from the last reset release, then sample 1 unit later.
   task automatic goto(input int k);
      repeat (k - cur) @(posedge clk);
      cur = k;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1 reset_n = 1'b1;
      cur = 0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_rst"},   {28'd0, rst_n_out}, 32'h0);
      check({tag, "_ready"}, {31'd0, ready},     32'h0);
      check({tag, "_ack"},   {31'd0, soft_ack},  32'h0);
`ifdef RST_EVT_CNT_EN
      check({tag, "_cnt"},   {30'd0, rst_evt_cnt}, 32'h0);
`endif
   endtask

   // Default timing: bit0@3, bit1@11, bit2@19, bit3@27, ready@28.
   task automatic power_on_checks(input string tag);
      goto(2);  check({tag, "_e2"},  {28'd0, rst_n_out}, 32'h0);
      goto(3);  check({tag, "_e3"},  {28'd0, rst_n_out}, 32'h1);
      goto(10); check({tag, "_e10"}, {28'd0, rst_n_out}, 32'h1);
      goto(11); check({tag, "_e11"}, {28'd0, rst_n_out}, 32'h3);
      goto(18); check({tag, "_e18"}, {28'd0, rst_n_out}, 32'h3);
      goto(19); check({tag, "_e19"}, {28'd0, rst_n_out}, 32'h7);
      goto(27); check({tag, "_e27"}, {28'd0, rst_n_out}, 32'hf);
      check({tag, "_rdy27"}, {31'd0, ready}, 32'h0);
      goto(28); check({tag, "_rdy28"}, {31'd0, ready}, 32'h1);
      check({tag, "_ack28"}, {31'd0, soft_ack}, 32'h0);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      cur      = 0;
      clk_en   = 1'b0;
      reset_n  = 1'b0;
      soft_req = 1'b0;

      // Power-on with clk stopped during reset.
      #1 check_cleared("por_hold");
      #54;
      reset_n = 1'b1;
      clk_en  = 1'b1;
      power_on_checks("por");

      // Soft reset sampled at E = 30.
      goto(29);
      soft_req = 1'b1;
      e = 30;
      goto(e);      check("soft_e_rst", {28'd0, rst_n_out}, 32'h0);
      check("soft_e_ready", {31'd0, ready}, 32'h0);
      goto(e + 15); check("soft_e15", {28'd0, rst_n_out}, 32'h0);
      goto(e + 16); check("soft_e16", {28'd0, rst_n_out}, 32'h1);
      goto(e + 40); check("soft_e40", {28'd0, rst_n_out}, 32'hf);
      check("soft_e40_ack", {31'd0, soft_ack}, 32'h0);
      goto(e + 41); check("soft_e41_ack", {31'd0, soft_ack}, 32'h1);
      check("soft_e41_ready", {31'd0, ready}, 32'h1);
      goto(e + 43); check("soft_ack_hold", {31'd0, soft_ack}, 32'h1);
      soft_req = 1'b0;
      goto(e + 44); check("soft_ack_drop", {31'd0, soft_ack}, 32'h0);
      check("soft_ready_run", {31'd0, ready}, 32'h1);
`ifdef RST_EVT_CNT_EN
      check("cnt_1", {30'd0, rst_evt_cnt}, 32'd1);
`endif

      // Four more handshakes; with CNT_W=2 the counter saturates at 3.
      for (int i = 0; i < 4; i++) begin
         soft_req = 1'b1;
         e = cur + 1;
         goto(e + 40); check("hs_pre_ack", {31'd0, soft_ack}, 32'h0);
         goto(e + 41); check("hs_ack", {31'd0, soft_ack}, 32'h1);
         soft_req = 1'b0;
         goto(e + 42); check("hs_ack_drop", {31'd0, soft_ack}, 32'h0);
`ifdef RST_EVT_CNT_EN
         check("hs_cnt", {30'd0, rst_evt_cnt}, (i < 1) ? 32'd2 : 32'd3);
`endif
      end

      // Full reset from RUN, then abort the next power-on between edges 12 and 13.
      reset_n = 1'b0;
      #1 check_cleared("run_reset");
      release_reset();
      goto(12); check("abort_pre", {28'd0, rst_n_out}, 32'h3);
      #3 reset_n = 1'b0;
      #1 check_cleared("abort");
      release_reset();
      power_on_checks("rerel");

      // Early request held from edge 5: serviced only from RUN, E = 29.
      reset_n = 1'b0;
      #1;
      release_reset();
      goto(4);
      soft_req = 1'b1;
      goto(27); check("early_e27_ready", {31'd0, ready}, 32'h0);
      goto(28); check("early_e28_ready", {31'd0, ready}, 32'h1);
      goto(29); check("early_e29_ready", {31'd0, ready}, 32'h0);
      check("early_e29_rst", {28'd0, rst_n_out}, 32'h0);
      goto(44); check("early_e44", {28'd0, rst_n_out}, 32'h0);
      goto(45); check("early_e45", {28'd0, rst_n_out}, 32'h1);
      goto(69); check("early_e69_ack", {31'd0, soft_ack}, 32'h0);
      goto(70); check("early_e70_ack", {31'd0, soft_ack}, 32'h1);
`ifdef RST_EVT_CNT_EN
      check("early_cnt", {30'd0, rst_evt_cnt}, 32'd1);
`endif

      // Reset glitch shorter than a cycle while held in ACK.
      goto(72); check("ack_held", {31'd0, soft_ack}, 32'h1);
      #2 reset_n = 1'b0;
      soft_req = 1'b0;
      #1 check_cleared("ack_glitch");
      #1 reset_n = 1'b1;
      cur = 0;
      goto(2);  check("glitch_e2", {28'd0, rst_n_out}, 32'h0);
      goto(3);  check("glitch_e3", {28'd0, rst_n_out}, 32'h1);
      goto(28); check("glitch_ready", {31'd0, ready}, 32'h1);
      check("glitch_ack", {31'd0, soft_ack}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
